// File: rtl/int_pow_pkg.sv
// Shared definitions for the integer power / log math blocks.
// Holds the sequencer state encoding and the exponent-width sanity check
// used at elaboration time by the log sequencer.
package int_pow_pkg;

   // Default operand and exponent widths for the pow/log family
   localparam int DEF_WIDTH = 12;
   localparam int DEF_EXPW  = 4;

   // Sequencer states: waiting for a request, iterating, holding a result
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True when an EXPW-bit exponent can hold every k up to WIDTH,
   // i.e. 2**expw - 1 >= width, expressed through clog2
   function automatic bit exp_width_ok(input int width, input int expw);
      return expw >= $clog2(width + 1);
   endfunction

endpackage

// File: rtl/int_log_step.sv
// One iteration of the integer log search.
// Multiplies the running power by the base at full double width so that
// overflow past WIDTH bits is never lost, and reports whether the next
// power still fits under the target value.
module int_log_step
   import int_pow_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] v,
   output logic             prod_le_v,
   output logic [WIDTH-1:0] next_acc
);

   logic [2*WIDTH-1:0] prod;

   // Full-width product and compare; the low half is only kept when it fits
   always_comb begin
      prod      = (2*WIDTH)'(acc) * (2*WIDTH)'(b);
      prod_le_v = (prod <= (2*WIDTH)'(v));
      next_acc  = prod[WIDTH-1:0];
   end

endmodule

// File: rtl/int_log_seq.sv
// Iterative integer logarithm: finds the largest k with b**k <= v.
// A request is accepted in IDLE, the search walks powers of b one multiply
// per cycle in CALC, and the result is held in DONE until the consumer takes
// it. Undefined logs (b<2 or v==0) skip straight to DONE with the error flag.
module int_log_seq
   import int_pow_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int EXPW  = DEF_EXPW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_base,
   input  logic [WIDTH-1:0] in_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EXPW-1:0]  out_exp,
   output logic             out_exact,
   output logic             out_err
);

   // Refuse to build a configuration whose exponent field could wrap
   if (!exp_width_ok(WIDTH, EXPW)) begin : g_bad_expw
      $error("int_log_seq: EXPW too narrow to hold exponents up to WIDTH");
   end

   state_t           state_q;
   logic [WIDTH-1:0] base_q;
   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] acc_q;
   logic [EXPW-1:0]  k_q;
   logic [EXPW-1:0]  exp_q;
   logic             exact_q;
   logic             err_q;

   logic             prod_le_v;
   logic [WIDTH-1:0] acc_d;

   // Multiply-and-compare for the current iteration
   int_log_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .acc       (acc_q),
      .b         (base_q),
      .v         (value_q),
      .prod_le_v (prod_le_v),
      .next_acc  (acc_d)
   );

   // Ready only in IDLE and never while reset is held, so nothing can be
   // accepted during the reset window
   assign in_ready  = (state_q == ST_IDLE) && rst_n;
   assign out_valid = (state_q == ST_DONE);
   assign out_exp   = exp_q;
   assign out_exact = exact_q;
   assign out_err   = err_q;

   // Sequencer: accept, iterate, hold result; result regs only change on
   // the edge that enters DONE so they stay stable while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         value_q <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         exp_q   <= '0;
         exact_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  if ((in_base >= WIDTH'(2)) && (in_value != '0)) begin
                     base_q  <= in_base;
                     value_q <= in_value;
                     acc_q   <= WIDTH'(1);
                     k_q     <= '0;
                     state_q <= ST_CALC;
                  end else begin
                     exp_q   <= '0;
                     err_q   <= 1'b1;
                     exact_q <= (in_base < WIDTH'(2)) && (in_value == WIDTH'(1));
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_CALC: begin
               if (prod_le_v) begin
                  acc_q <= acc_d;
                  k_q   <= k_q + EXPW'(1);
               end else begin
                  exp_q   <= k_q;
                  exact_q <= (acc_q == value_q);
                  err_q   <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_log_seq.sv
// Self-checking bench for int_log_seq: a table of directed cases, hand
// sequences for stall and mid-search reset, and a random back-to-back run
// scored against a pow-based reference model.
module tb_int_log_seq;

   localparam int WIDTH = 12;
   localparam int EXPW  = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_base;
   logic [WIDTH-1:0] in_value;
   logic             out_valid;
   logic             out_ready;
   logic [EXPW-1:0]  out_exp;
   logic             out_exact;
   logic             out_err;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      string name;
      int    b;
      int    v;
      int    k;
      int    exact;
      int    err;
   } vec_t;

   typedef struct {
      int k;
      int exact;
      int err;
   } res_t;

   int_log_seq #(
      .WIDTH(WIDTH),
      .EXPW (EXPW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_base   (in_base),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_exp   (out_exp),
      .out_exact (out_exact),
      .out_err   (out_err)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Integer power by repeated multiplication, wide enough to never overflow here
   function automatic longint powL(input longint b, input int e);
      longint p = 1;
      for (int i = 0; i < e; i++) p = p * b;
      return p;
   endfunction

   // Reference: largest k with b**k <= v, plus exactness and undefined-log flag
   function automatic res_t refLog(input int b, input int v);
      res_t r;
      if (b < 2 || v == 0) begin
         r.k     = 0;
         r.err   = 1;
         r.exact = (b < 2 && v == 1) ? 1 : 0;
      end else begin
         r.k   = 0;
         r.err = 0;
         while (powL(b, r.k + 1) <= longint'(v)) r.k++;
         r.exact = (powL(b, r.k) == longint'(v)) ? 1 : 0;
      end
      return r;
   endfunction

   // One scored comparison
   task automatic checkOutput(input string name, input int actual, input int expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Present a request and let it be accepted on the next edge; returns #1 after the accept edge
   task automatic applyStimulus(input int b, input int v);
      int waitCycles = 0;
      @(negedge clk);
      in_base  = WIDTH'(b);
      in_value = WIDTH'(v);
      in_valid = 1'b1;
      while (!in_ready && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("inReadyBeforeAccept", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_base  = WIDTH'($urandom);
      in_value = WIDTH'($urandom);
   endtask

   // Wait for the result, check latency and fields, optionally stall, then release it
   task automatic collectResult(input string name, input int ek, input int eex,
                                input int eerr, input int stall);
      int lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({name, ".valid"},   int'(out_valid), 1);
      checkOutput({name, ".latency"}, lat, (eerr != 0) ? 1 : ek + 2);
      checkOutput({name, ".exp"},     int'(out_exp),   ek);
      checkOutput({name, ".exact"},   int'(out_exact), eex);
      checkOutput({name, ".err"},     int'(out_err),   eerr);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         checkOutput({name, ".stallValid"}, int'(out_valid), 1);
         checkOutput({name, ".stallExp"},   int'(out_exp),   ek);
         checkOutput({name, ".stallExact"}, int'(out_exact), eex);
         checkOutput({name, ".stallReady"}, int'(in_ready),  0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({name, ".dropValid"}, int'(out_valid), 0);
      checkOutput({name, ".readyBack"}, int'(in_ready),  1);
   endtask

   vec_t vecs[$];

   initial begin
      res_t q[$];
      res_t r;
      res_t e;
      int   accepted;
      int   cycles;
      int   rb;
      int   rv;

      vecs.push_back('{"pow2_1024",  2,    1024, 10, 1, 0});
      vecs.push_back('{"b3_v100",    3,    100,  4,  0, 0});
      vecs.push_back('{"b4095_4095", 4095, 4095, 1,  1, 0});
      vecs.push_back('{"b0_v1",      0,    1,    0,  1, 1});
      vecs.push_back('{"b0_v0",      0,    0,    0,  0, 1});
      vecs.push_back('{"b5_v0",      5,    0,    0,  0, 1});
      vecs.push_back('{"b1_v1",      1,    1,    0,  1, 1});
      vecs.push_back('{"b1_v4095",   1,    4095, 0,  0, 1});
      vecs.push_back('{"b2_v4095",   2,    4095, 11, 0, 0});
      vecs.push_back('{"b4095_4094", 4095, 4094, 0,  0, 0});
      vecs.push_back('{"b7_v1",      7,    1,    0,  1, 0});
      vecs.push_back('{"b64_v4095",  64,   4095, 1,  0, 0});
      vecs.push_back('{"b3_v2187",   3,    2187, 7,  1, 0});

      in_valid  = 1'b0;
      in_base   = '0;
      in_value  = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst.inReady",  int'(in_ready),  0);
      checkOutput("rst.outValid", int'(out_valid), 0);
      checkOutput("rst.outExp",   int'(out_exp),   0);
      checkOutput("rst.outExact", int'(out_exact), 0);
      checkOutput("rst.outErr",   int'(out_err),   0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst.readyAfter", int'(in_ready), 1);

      // Directed table
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].b, vecs[i].v);
         collectResult(vecs[i].name, vecs[i].k, vecs[i].exact, vecs[i].err, 0);
      end

      // Stall in DONE with a second request waiting the whole time
      applyStimulus(3, 100);
      in_base  = WIDTH'(3);
      in_value = WIDTH'(9);
      in_valid = 1'b1;
      collectResult("stall", 4, 0, 0, 5);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      collectResult("afterStall", 2, 1, 0, 0);

      // Reset in the middle of a long search
      applyStimulus(2, 4095);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midRst.outValid", int'(out_valid), 0);
      checkOutput("midRst.inReady",  int'(in_ready),  0);
      checkOutput("midRst.outExp",   int'(out_exp),   0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midRst.readyAfter", int'(in_ready), 1);
      applyStimulus(2, 8);
      collectResult("postRst", 3, 1, 0, 0);

      // Back-to-back random requests with a consumer that never stalls
      accepted  = 0;
      cycles    = 0;
      out_ready = 1'b1;
      while ((accepted < 100 || q.size() != 0) && cycles < 20000) begin
         @(negedge clk);
         cycles++;
         if (out_valid) begin
            if (q.size() == 0) begin
               checkOutput("rand.unexpectedResult", 1, 0);
            end else begin
               e = q.pop_front();
               checkOutput("rand.exp",   int'(out_exp),   e.k);
               checkOutput("rand.exact", int'(out_exact), e.exact);
               checkOutput("rand.err",   int'(out_err),   e.err);
            end
         end
         if (accepted < 100) begin
            case ($urandom_range(0, 3))
               0:       rb = int'($urandom_range(0, 1));
               1:       rb = int'($urandom_range(2, 16));
               2:       rb = int'($urandom_range(2, 64));
               default: rb = int'($urandom_range(2, 4095));
            endcase
            if ($urandom_range(0, 9) == 0) rv = int'($urandom_range(0, 1));
            else                           rv = int'($urandom_range(0, 4095));
            in_base  = WIDTH'(rb);
            in_value = WIDTH'(rv);
            in_valid = 1'b1;
            if (in_ready) begin
               r = refLog(rb, rv);
               q.push_back(r);
               accepted++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      if (cycles >= 20000) checkOutput("rand.timeout", cycles, 0);
      out_ready = 1'b0;
      in_valid  = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
